cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) among the ALU, branch and LSU functional units.
- Each FU writes its result into a private one-entry holding buffer. A round-robin arbiter grants one buffered result per cycle into a registered CDB stage.
- The CDB stage drives PRF writeback, wakes up the reservation stations and marks ROB completion.
- On a branch mispredict, results younger than the mispredicting branch are squashed from the buffers, the CDB stage and any same-cycle input.

---
 rtl/cdb_arbiter_pkg.sv | 39 +++
 rtl/cdb_arbiter_if.sv | 40 ++++
 rtl/cdb_arbiter_rr_arbiter.sv | 55 +++++
 rtl/cdb_arbiter.sv | 109 ++++++++++
 tb/tb_cdb_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus (CDB) arbiter, ROB and reservation stations.
// Provides the bus geometry, requester indices, the CDB packet type and the
// ROB age comparison used to decide what a mispredict squashes.
package cdb_arbiter_pkg;

    localparam int unsigned NUM_REQ   = 3;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned PREG_W    = 7;
    localparam int unsigned ROB_TAG_W = 4;
    localparam int unsigned SRC_W     = 2;

    // Requester indices on the arbiter
    localparam int unsigned ALU_IDX = 0;
    localparam int unsigned BR_IDX  = 1;
    localparam int unsigned LSU_IDX = 2;

    typedef logic [ROB_TAG_W-1:0] rob_tag_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [PREG_W-1:0] prd;
        logic              we;
        rob_tag_t          rob_tag;
    } cdb_packet_t;

    // True when tag is strictly younger than flush_tag, ages measured from the ROB head.
    // Modular subtraction makes tag wrap-around transparent.
    function automatic logic rob_is_younger(input rob_tag_t tag,
                                            input rob_tag_t flush_tag,
                                            input rob_tag_t head);
        rob_tag_t tag_age;
        rob_tag_t flush_age;
        tag_age   = tag - head;
        flush_age = flush_tag - head;
        return tag_age > flush_age;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU result handshake, flush control and CDB broadcast bundle.
//   fu_*        : per-FU result offer (valid/ready handshake) and payload
//   rob_head    : oldest in-flight ROB tag, reference for age comparisons
//   mispredict* : flush request and the mispredicting branch's tag
//   cdb_*       : registered broadcast to PRF, reservation stations and ROB
// master = FU/ROB side, slave = arbiter.
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    logic [NUM_REQ-1:0]                fu_valid_in;
    logic [NUM_REQ-1:0]                fu_ready_out;
    logic [NUM_REQ-1:0][DATA_W-1:0]    fu_data_in;
    logic [NUM_REQ-1:0][PREG_W-1:0]    fu_prd_in;
    logic [NUM_REQ-1:0]                fu_we_in;
    logic [NUM_REQ-1:0][ROB_TAG_W-1:0] fu_rob_tag_in;
    logic [ROB_TAG_W-1:0]              rob_head;
    logic                              mispredict;
    logic [ROB_TAG_W-1:0]              mispredict_tag;
    logic                              cdb_valid;
    logic [DATA_W-1:0]                 cdb_data;
    logic [PREG_W-1:0]                 cdb_prd;
    logic                              cdb_we;
    logic [ROB_TAG_W-1:0]              cdb_rob_tag;
    logic [SRC_W-1:0]                  cdb_src;

    modport master (
        output fu_valid_in, fu_data_in, fu_prd_in, fu_we_in, fu_rob_tag_in,
        output rob_head, mispredict, mispredict_tag,
        input  fu_ready_out,
        input  cdb_valid, cdb_data, cdb_prd, cdb_we, cdb_rob_tag, cdb_src
    );

    modport slave (
        input  fu_valid_in, fu_data_in, fu_prd_in, fu_we_in, fu_rob_tag_in,
        input  rob_head, mispredict, mispredict_tag,
        output fu_ready_out,
        output cdb_valid, cdb_data, cdb_prd, cdb_we, cdb_rob_tag, cdb_src
    );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer in
// cyclic order; the pointer moves just past the winner and holds when idle.
//   clk, rst_n   : clock, async active-low reset (pointer -> 0)
//   req          : request vector
//   grant_c      : one-hot grant (combinational)
//   grant_idx_c  : index of the granted requester (combinational)
//   grant_any_c  : any request granted (combinational)
module cdb_arbiter_rr_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [SRC_W-1:0]   grant_idx_c,
    output logic               grant_any_c
);

    logic [SRC_W-1:0] ptr_q;
    logic [SRC_W-1:0] ptr_d;

    // Cyclic priority search starting at the pointer
    always_comb begin : pick
        logic [SRC_W-1:0] idx;
        grant_c     = '0;
        grant_idx_c = '0;
        grant_any_c = 1'b0;
        idx         = ptr_q;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            if (!grant_any_c && req[idx]) begin
                grant_any_c  = 1'b1;
                grant_c[idx] = 1'b1;
                grant_idx_c  = idx;
            end
            idx = (idx == SRC_W'(NUM_REQ - 1)) ? '0 : idx + SRC_W'(1);
        end
    end

    // Pointer advance
    always_comb begin
        ptr_d = ptr_q;
        if (grant_any_c) begin
            ptr_d = (grant_idx_c == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + SRC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: each FU result lands in a one-entry holding buffer; a
// round-robin arbiter moves one buffered result per cycle into the registered
// CDB stage. A mispredict squashes younger entries from the buffers, from the
// entry being loaded into the CDB and from same-cycle FU inputs.
//   clk   : clock
//   reset : async active-low reset
//   bus   : FU handshakes, flush control and CDB broadcast (slave side)
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);

    cdb_packet_t [NUM_REQ-1:0] buf_q;
    cdb_packet_t [NUM_REQ-1:0] buf_d;
    cdb_packet_t               cdb_q;
    cdb_packet_t               cdb_d;
    logic [SRC_W-1:0]          src_q;
    logic [SRC_W-1:0]          src_d;

    logic [NUM_REQ-1:0]        buf_valid_c;
    logic [NUM_REQ-1:0]        buf_kill_c;
    logic [NUM_REQ-1:0]        arb_req_c;
    logic [NUM_REQ-1:0]        grant_c;
    logic [NUM_REQ-1:0]        ready_c;
    logic [SRC_W-1:0]          grant_idx_c;
    logic                      grant_any_c;

    // Killed buffers are withheld from arbitration so a squashed result never
    // reaches the CDB. Only buffer state and flush control feed the grant.
    always_comb begin
        buf_valid_c = '0;
        buf_kill_c  = '0;
        arb_req_c   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            buf_valid_c[i] = buf_q[i].valid;
            buf_kill_c[i]  = bus.mispredict && buf_q[i].valid &&
                             rob_is_younger(buf_q[i].rob_tag, bus.mispredict_tag, bus.rob_head);
            arb_req_c[i]   = buf_q[i].valid && !buf_kill_c[i];
        end
    end

    cdb_arbiter_rr_arbiter u_rr_arbiter (
        .clk         (clk),
        .rst_n       (reset),
        .req         (arb_req_c),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c),
        .grant_any_c (grant_any_c)
    );

    // A draining buffer can refill in the same cycle
    assign ready_c = ~buf_valid_c | grant_c;

    // Holding buffer update: accept wins over drain/kill; younger inputs are
    // handshaken but not stored during a flush.
    always_comb begin
        buf_d = buf_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (bus.fu_valid_in[i] && ready_c[i]) begin
                buf_d[i].valid   = !(bus.mispredict &&
                                     rob_is_younger(bus.fu_rob_tag_in[i], bus.mispredict_tag,
                                                    bus.rob_head));
                buf_d[i].data    = bus.fu_data_in[i];
                buf_d[i].prd     = bus.fu_prd_in[i];
                buf_d[i].we      = bus.fu_we_in[i];
                buf_d[i].rob_tag = bus.fu_rob_tag_in[i];
            end else if (grant_c[i] || buf_kill_c[i]) begin
                buf_d[i].valid = 1'b0;
            end
        end
    end

    // CDB stage load; payload holds when idle, write enable follows valid
    always_comb begin
        cdb_d       = cdb_q;
        src_d       = src_q;
        cdb_d.valid = 1'b0;
        cdb_d.we    = 1'b0;
        if (grant_any_c) begin
            cdb_d       = buf_q[grant_idx_c];
            cdb_d.valid = 1'b1;
            src_d       = grant_idx_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q <= '0;
            cdb_q <= '0;
            src_q <= '0;
        end else begin
            buf_q <= buf_d;
            cdb_q <= cdb_d;
            src_q <= src_d;
        end
    end

    assign bus.fu_ready_out = ready_c;
    assign bus.cdb_valid    = cdb_q.valid;
    assign bus.cdb_data     = cdb_q.data;
    assign bus.cdb_prd      = cdb_q.prd;
    assign bus.cdb_we       = cdb_q.we;
    assign bus.cdb_rob_tag  = cdb_q.rob_tag;
    assign bus.cdb_src      = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scenario bench for cdb_arbiter: expected broadcasts are queued as stimulus is
// driven and checked in order by a monitor whenever the CDB is valid.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    typedef struct {
        logic [DATA_W-1:0]    data;
        logic [PREG_W-1:0]    prd;
        logic [ROB_TAG_W-1:0] tag;
        logic [SRC_W-1:0]     src;
        logic                 we;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    cdb_arbiter_if bus();

    cdb_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;

    // Scoreboard monitor: every valid broadcast must match the next expectation
    always @(negedge clk) begin
        if (mon_en && reset === 1'b1 && bus.cdb_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL cdb_unexpected: got data=%h prd=%0d tag=%0d src=%0d, required no broadcast",
                         bus.cdb_data, bus.cdb_prd, bus.cdb_rob_tag, bus.cdb_src);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.cdb_data, bus.cdb_prd, bus.cdb_rob_tag, bus.cdb_src, bus.cdb_we} !==
                    {mon_e.data, mon_e.prd, mon_e.tag, mon_e.src, mon_e.we}) begin
                    $display("FAIL cdb_packet: got data=%h prd=%0d tag=%0d src=%0d we=%b, required data=%h prd=%0d tag=%0d src=%0d we=%b",
                             bus.cdb_data, bus.cdb_prd, bus.cdb_rob_tag, bus.cdb_src, bus.cdb_we,
                             mon_e.data, mon_e.prd, mon_e.tag, mon_e.src, mon_e.we);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.fu_valid_in    = '0;
        bus.fu_data_in     = '0;
        bus.fu_prd_in      = '0;
        bus.fu_we_in       = '0;
        bus.fu_rob_tag_in  = '0;
        bus.mispredict     = 1'b0;
        bus.mispredict_tag = '0;
    endtask

    task automatic drive_fu(input int idx, input logic [DATA_W-1:0] d,
                            input logic [PREG_W-1:0] p, input logic [ROB_TAG_W-1:0] t,
                            input logic w);
        bus.fu_valid_in[idx]   = 1'b1;
        bus.fu_data_in[idx]    = d;
        bus.fu_prd_in[idx]     = p;
        bus.fu_rob_tag_in[idx] = t;
        bus.fu_we_in[idx]      = w;
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] d, input logic [PREG_W-1:0] p,
                            input logic [ROB_TAG_W-1:0] t, input int src, input logic w);
        exp_t e;
        e.data = d;
        e.prd  = p;
        e.tag  = t;
        e.src  = SRC_W'(src);
        e.we   = w;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int c = 0; c < max_cycles && exp_q.size() != 0; c++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        bus.rob_head = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.cdb_valid, bus.cdb_data, bus.cdb_prd, bus.cdb_we, bus.cdb_rob_tag, bus.cdb_src} !== '0)
            $display("FAIL reset_cdb: got valid=%b data=%h prd=%0d we=%b tag=%0d src=%0d, required all 0",
                     bus.cdb_valid, bus.cdb_data, bus.cdb_prd, bus.cdb_we, bus.cdb_rob_tag, bus.cdb_src);
        else n_pass++;
        n_checks++;
        if (bus.fu_ready_out !== 3'b111)
            $display("FAIL reset_ready: got %b, required 111", bus.fu_ready_out);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        step();
        n_checks++;
        if (bus.fu_ready_out !== 3'b111)
            $display("FAIL release_ready: got %b, required 111", bus.fu_ready_out);
        else n_pass++;
        mon_en = 1'b1;
    endtask

    task automatic test_contention();
        step();
        drive_fu(ALU_IDX, 32'h1001, 7'd10, 4'd1, 1'b1);
        drive_fu(BR_IDX,  32'h2002, 7'd11, 4'd2, 1'b0);
        drive_fu(LSU_IDX, 32'h3003, 7'd12, 4'd3, 1'b1);
        push_exp(32'h1001, 7'd10, 4'd1, 0, 1'b1);
        push_exp(32'h2002, 7'd11, 4'd2, 1, 1'b0);
        push_exp(32'h3003, 7'd12, 4'd3, 2, 1'b1);
        step();
        idle_inputs();
        n_checks++;
        if (bus.fu_ready_out !== 3'b001)
            $display("FAIL contention_ready: got %b, required 001", bus.fu_ready_out);
        else n_pass++;
        wait_drain(10);
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL contention_drain: got %0d pending, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int   idx;
        int   low_cnt;
        logic rdy;
        idx     = 0;
        low_cnt = 0;
        step();
        push_exp(32'hA0, 7'd20, 4'd4, 0, 1'b1);
        push_exp(32'hB0, 7'd30, 4'd8, 1, 1'b1);
        push_exp(32'hA1, 7'd21, 4'd5, 0, 1'b1);
        push_exp(32'hA2, 7'd22, 4'd6, 0, 1'b1);
        push_exp(32'hA3, 7'd23, 4'd7, 0, 1'b1);
        for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
            drive_fu(ALU_IDX, DATA_W'(32'hA0 + idx), PREG_W'(20 + idx), ROB_TAG_W'(4 + idx), 1'b1);
            if (cyc == 0) drive_fu(BR_IDX, 32'hB0, 7'd30, 4'd8, 1'b1);
            else bus.fu_valid_in[BR_IDX] = 1'b0;
            #1;
            rdy = bus.fu_ready_out[ALU_IDX];
            if (!rdy) low_cnt++;
            @(posedge clk);
            #1;
            if (rdy) idx++;
        end
        idle_inputs();
        n_checks++;
        if (low_cnt != 1)
            $display("FAIL b2b_ready_low_cycles: got %0d, required 1", low_cnt);
        else n_pass++;
        wait_drain(10);
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_single();
        step();
        drive_fu(ALU_IDX, 32'h000000AA, 7'd5, 4'd3, 1'b1);
        push_exp(32'h000000AA, 7'd5, 4'd3, 0, 1'b1);
        step();
        idle_inputs();
        n_checks++;
        if (bus.fu_ready_out[ALU_IDX] !== 1'b1)
            $display("FAIL single_alu_ready: got %b, required 1", bus.fu_ready_out[ALU_IDX]);
        else n_pass++;
        wait_drain(10);
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL single_drain: got %0d pending, required 0", exp_q.size());
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.cdb_valid, bus.cdb_we, bus.cdb_data} !== {1'b0, 1'b0, 32'h000000AA})
            $display("FAIL single_hold: got valid=%b we=%b data=%h, required valid=0 we=0 data=000000aa",
                     bus.cdb_valid, bus.cdb_we, bus.cdb_data);
        else n_pass++;
    endtask

    task automatic test_flush();
        step();
        bus.rob_head = 4'd0;
        drive_fu(ALU_IDX, 32'hC2, 7'd40, 4'd2, 1'b1);
        drive_fu(LSU_IDX, 32'hC5, 7'd41, 4'd5, 1'b1);
        push_exp(32'hC2, 7'd40, 4'd2, 0, 1'b1);
        step();
        idle_inputs();
        bus.mispredict     = 1'b1;
        bus.mispredict_tag = 4'd3;
        #1;
        n_checks++;
        if (bus.fu_ready_out !== 3'b011)
            $display("FAIL flush_ready_during: got %b, required 011", bus.fu_ready_out);
        else n_pass++;
        step();
        idle_inputs();
        n_checks++;
        if (bus.fu_ready_out !== 3'b111)
            $display("FAIL flush_ready_after: got %b, required 111", bus.fu_ready_out);
        else n_pass++;
        wait_drain(10);
        repeat (3) step();
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL flush_drain: got %0d pending, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_wrap_flush();
        step();
        bus.rob_head = 4'd14;
        drive_fu(BR_IDX,  32'hD15, 7'd50, 4'd15, 1'b1);
        drive_fu(LSU_IDX, 32'hD01, 7'd51, 4'd1,  1'b1);
        push_exp(32'hD15, 7'd50, 4'd15, 1, 1'b1);
        step();
        idle_inputs();
        bus.mispredict     = 1'b1;
        bus.mispredict_tag = 4'd15;
        drive_fu(ALU_IDX, 32'hD00, 7'd52, 4'd0, 1'b1);
        #1;
        n_checks++;
        if (bus.fu_ready_out !== 3'b011)
            $display("FAIL wrap_ready_during: got %b, required 011", bus.fu_ready_out);
        else n_pass++;
        step();
        idle_inputs();
        n_checks++;
        if (bus.fu_ready_out !== 3'b111)
            $display("FAIL wrap_ready_after: got %b, required 111", bus.fu_ready_out);
        else n_pass++;
        wait_drain(10);
        repeat (3) step();
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL wrap_drain: got %0d pending, required 0", exp_q.size());
        else n_pass++;
        bus.rob_head = 4'd0;
    endtask

    task automatic test_reset_mid();
        mon_en = 1'b0;
        step();
        drive_fu(ALU_IDX, 32'hE1, 7'd60, 4'd1, 1'b1);
        drive_fu(BR_IDX,  32'hE2, 7'd61, 4'd2, 1'b1);
        drive_fu(LSU_IDX, 32'hE3, 7'd62, 4'd3, 1'b1);
        step();
        idle_inputs();
        drive_fu(LSU_IDX, 32'hE4, 7'd63, 4'd4, 1'b1);
        step();
        idle_inputs();
        n_checks++;
        if ({bus.cdb_valid, bus.fu_ready_out} !== {1'b1, 3'b001})
            $display("FAIL mid_full_state: got valid=%b ready=%b, required valid=1 ready=001",
                     bus.cdb_valid, bus.fu_ready_out);
        else n_pass++;
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.cdb_valid, bus.cdb_data, bus.cdb_prd, bus.cdb_we, bus.cdb_rob_tag, bus.cdb_src} !== '0)
            $display("FAIL mid_async_cdb: got valid=%b data=%h prd=%0d we=%b tag=%0d src=%0d, required all 0",
                     bus.cdb_valid, bus.cdb_data, bus.cdb_prd, bus.cdb_we, bus.cdb_rob_tag, bus.cdb_src);
        else n_pass++;
        n_checks++;
        if (bus.fu_ready_out !== 3'b111)
            $display("FAIL mid_async_ready: got %b, required 111", bus.fu_ready_out);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        step();
        drive_fu(ALU_IDX, 32'hF1, 7'd70, 4'd5, 1'b0);
        drive_fu(BR_IDX,  32'hF2, 7'd71, 4'd6, 1'b1);
        drive_fu(LSU_IDX, 32'hF3, 7'd72, 4'd7, 1'b1);
        push_exp(32'hF1, 7'd70, 4'd5, 0, 1'b0);
        push_exp(32'hF2, 7'd71, 4'd6, 1, 1'b1);
        push_exp(32'hF3, 7'd72, 4'd7, 2, 1'b1);
        step();
        idle_inputs();
        wait_drain(10);
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL mid_after_release_drain: got %0d pending, required 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_back_to_back();
        test_single();
        test_flush();
        test_wrap_flush();
        test_reset_mid();
        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
